// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and legality check used by the ALU
// and by its downstream retire stage.
package alu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] ADD   = 4'd0;
    localparam logic [OPW-1:0] SUB   = 4'd1;
    localparam logic [OPW-1:0] AND   = 4'd2;
    localparam logic [OPW-1:0] OR    = 4'd3;
    localparam logic [OPW-1:0] SLL   = 4'd4;
    localparam logic [OPW-1:0] MUL   = 4'd5;
    localparam logic [OPW-1:0] SEQ   = 4'd6;
    localparam logic [OPW-1:0] SRL   = 4'd7;
    localparam logic [OPW-1:0] PASSB = 4'd8;

    function automatic logic is_legal_op(input logic [OPW-1:0] opcode);
        return opcode <= PASSB;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap by plain overflow.
module alu_result_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: state updates use non-blocking assignments so every register in
    // the design samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which slots are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Retire stage behind the combinational ALU: normalises flags at capture,
// buffers entries in a FIFO and counts retired operations.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    parameter int CNTW  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPW-1:0]          in_opcode,
    input  logic [WIDTH-1:0]        in_result,
    input  logic                    in_carry,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPW-1:0]          out_opcode,
    output logic [WIDTH-1:0]        out_result,
    output logic                    out_carry,
    output logic                    out_zero,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [CNTW-1:0]         retired_count
);

    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             illegal;
    } entry_t;

    entry_t wr_entry;
    entry_t head;
    entry_t held;
    entry_t shown;
    logic   push;
    logic   pop;
    logic   full;
    logic   empty;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: every field gets a default first so no path leaves a latch.
    always_comb begin
        wr_entry        = '0;
        wr_entry.opcode = in_opcode;
        if (is_legal_op(in_opcode)) begin
            wr_entry.carry  = (in_opcode == ADD || in_opcode == SUB) ? in_carry : 1'b0;
            wr_entry.result = (in_opcode == SEQ) ? '0 : in_result;
        end else begin
            wr_entry.illegal = 1'b1;
        end
        wr_entry.zero = (wr_entry.result == '0);
    end

    alu_result_fifo #(
        .DW    ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .count   (occupancy),
        .full    (full),
        .empty   (empty)
    );

    // Last retired entry keeps the outputs stable while the stage is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held          <= '0;
            retired_count <= '0;
        end else if (pop) begin
            held <= head;
            if (retired_count != '1) retired_count <= retired_count + 1'b1;
        end
    end

    assign shown       = empty ? held : head;
    assign out_opcode  = shown.opcode;
    assign out_result  = shown.result;
    assign out_carry   = shown.carry;
    assign out_zero    = shown.zero;
    assign out_illegal = shown.illegal;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios plus random
// traffic, checked against a rule-level reference model.
module tb_alu_result_stage;

    localparam int WIDTH = 128;
    localparam int DEPTH = 4;
    localparam int CNTW  = 4;
    localparam int SAT   = 15;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             illegal;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_opcode;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_illegal;
    logic [2:0]       occupancy;
    logic [CNTW-1:0]  retired_count;

    exp_t q[$];
    exp_t last_exp;
    int   model_cnt;
    int   n_cmp;
    int   n_fail;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_result     (in_result),
        .in_carry      (in_carry),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opcode    (out_opcode),
        .out_result    (out_result),
        .out_carry     (out_carry),
        .out_zero      (out_zero),
        .out_illegal   (out_illegal),
        .occupancy     (occupancy),
        .retired_count (retired_count)
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] r, input logic c);
        exp_t e;
        e.op      = op;
        e.illegal = (op > 4'd8);
        e.carry   = (op == 4'd0 || op == 4'd1) ? c : 1'b0;
        e.result  = (op == 4'd6 || op > 4'd8) ? '0 : r;
        e.zero    = (e.result == '0);
        return e;
    endfunction

    function automatic exp_t zero_entry();
        exp_t e;
        e.op = '0; e.result = '0; e.carry = 1'b0; e.zero = 1'b0; e.illegal = 1'b0;
        return e;
    endfunction

    // Pop monitor: every output handshake is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("pop_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("out_opcode",  out_opcode,  e.op);
                    check("out_result",  out_result,  e.result);
                    check("out_carry",   out_carry,   e.carry);
                    check("out_zero",    out_zero,    e.zero);
                    check("out_illegal", out_illegal, e.illegal);
                    last_exp = e;
                    if (model_cnt < SAT) model_cnt++;
                end
            end
        end
    end

    // State monitor: occupancy, flow control and held outputs after each edge.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (!rst) begin
                check("occupancy", occupancy, q.size());
                check("in_ready",  in_ready,  q.size() < DEPTH);
                check("out_valid", out_valid, q.size() != 0);
                check("retired_count", retired_count, model_cnt);
                if (!out_valid) begin
                    check("held_result", out_result, last_exp.result);
                    check("held_opcode", out_opcode, last_exp.op);
                end else if (q.size() != 0) begin
                    check("head_result", out_result, q[0].result);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // Called at posedge+1; applies one cycle of stimulus and records a push.
    task automatic drive(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] r,
                         input logic c, input logic rdy);
        in_valid  = v;
        in_opcode = op;
        in_result = v ? r : 'x;
        in_carry  = c;
        out_ready = rdy;
        @(negedge clk);
        if (in_valid && in_ready) q.push_back(model(op, r, c));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            drive(1'b0, 4'd0, '0, 1'b0, 1'b1);
            n++;
        end
        check("drain_timeout", n < 50, 1);
    endtask

    // Asserts rst between clock edges and checks the immediate effect.
    task automatic async_reset();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_retired",   retired_count, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_carry", out_carry, 0);
        q.delete();
        last_exp  = zero_entry();
        model_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        n_cmp = 0; n_fail = 0; model_cnt = 0;
        last_exp  = zero_entry();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_result = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single ADD through the stage.
        drive(1'b1, 4'd0, 128'h5, 1'b1, 1'b0);
        drive(1'b0, 4'd0, '0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, '0, 1'b0, 1'b1);

        // Fill under backpressure, refuse fifth, then full with pop-only and push+pop.
        drive(1'b1, 4'd2, 128'hA0, 1'b1, 1'b0);
        drive(1'b1, 4'd3, 128'hB1, 1'b1, 1'b0);
        drive(1'b1, 4'd5, 128'hC2, 1'b0, 1'b0);
        drive(1'b1, 4'd8, 128'hD3, 1'b1, 1'b0);
        check("full_in_ready", in_ready, 0);
        drive(1'b1, 4'd7, 128'hE4, 1'b0, 1'b0);
        drive(1'b1, 4'd4, 128'hF5, 1'b0, 1'b1);
        check("after_full_pop", occupancy, 3);
        drive(1'b1, 4'd1, 128'h16, 1'b1, 1'b1);
        check("push_pop_steady", occupancy, 3);
        drain();

        // SEQ result suppression and illegal opcode.
        drive(1'b1, 4'd6,  128'hDEAD, 1'b1, 1'b0);
        drive(1'b1, 4'd12, 128'h1,    1'b1, 1'b0);
        drain();

        // Async reset with two entries queued, then recovery.
        drive(1'b1, 4'd1, 128'h0, 1'b1, 1'b0);
        drive(1'b1, 4'd0, 128'h77, 1'b0, 1'b0);
        async_reset();
        drive(1'b1, 4'd3, 128'h99, 1'b0, 1'b0);
        drain();

        // Counter saturation: 20 back-to-back transactions from a fresh reset.
        async_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, 4'd0, 128'(i + 1), 1'b1, 1'b1);
        drain();
        check("sat_count", retired_count, SAT);

        // Random traffic.
        async_reset();
        for (int i = 0; i < 400; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) r = '0;
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), r,
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
